// File: rtl/btn_dip_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_dip_conditioner : synchronise and debounce 4 buttons + 5 DIP sliders,
//                       derive press/relock pulses and a one-hot digit select.
// Rev 1.0
// ----------------------------------------------------------------------------
module btn_dip_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn_i,
   input  logic [4:0] dip_i,
   output logic [3:0] btn_level_o,
   output logic [3:0] btn_press_o,
   output logic [4:0] dip_level_o,
   output logic       dip_sel_valid_o,
   output logic [1:0] dip_sel_idx_o,
   output logic       relock_pulse_o
);

   localparam int               NCH    = 9;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } state_t;

   logic [NCH-1:0] w_raw;
   logic [NCH-1:0] w_level;

   // Channel map: [3:0] buttons, [8:4] sliders (slider 4 is relock).
   assign w_raw = {dip_i, btn_i};

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      state_t                 state_q, state_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   w_in;

      assign w_in = sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
         end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], w_raw[i]};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         level_d = level_q;
         case (state_q)
            STABLE_LO: begin
               if (w_in) begin
                  state_d = WAIT_HI;
                  cnt_d   = C_ONE;
               end
            end
            WAIT_HI: begin
               if (!w_in) begin
                  state_d = STABLE_LO;
                  cnt_d   = '0;
               end else if (cnt_q == C_LAST) begin
                  state_d = STABLE_HI;
                  cnt_d   = '0;
                  level_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + C_ONE;
               end
            end
            STABLE_HI: begin
               if (!w_in) begin
                  state_d = WAIT_LO;
                  cnt_d   = C_ONE;
               end
            end
            WAIT_LO: begin
               if (w_in) begin
                  state_d = STABLE_HI;
                  cnt_d   = '0;
               end else if (cnt_q == C_LAST) begin
                  state_d = STABLE_LO;
                  cnt_d   = '0;
                  level_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + C_ONE;
               end
            end
            default: begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               level_d = 1'b0;
            end
         endcase
      end

      assign w_level[i] = level_q;

      // Pulse registers exist only on channels that export a rising-edge pulse.
      if (i < 4) begin : g_press
         logic press_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) press_q <= 1'b0;
            else        press_q <= (state_q == WAIT_HI) && w_in && (cnt_q == C_LAST);
         end
         assign btn_press_o[i] = press_q;
      end else if (i == NCH - 1) begin : g_relock
         logic relock_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) relock_q <= 1'b0;
            else        relock_q <= (state_q == WAIT_HI) && w_in && (cnt_q == C_LAST);
         end
         assign relock_pulse_o = relock_q;
      end
   end

   logic       sel_valid_q, sel_valid_d;
   logic [1:0] sel_idx_q, sel_idx_d;

   always_comb begin
      sel_valid_d = 1'b0;
      sel_idx_d   = 2'd0;
      case (w_level[7:4])
         4'b0001: begin sel_valid_d = 1'b1; sel_idx_d = 2'd0; end
         4'b0010: begin sel_valid_d = 1'b1; sel_idx_d = 2'd1; end
         4'b0100: begin sel_valid_d = 1'b1; sel_idx_d = 2'd2; end
         4'b1000: begin sel_valid_d = 1'b1; sel_idx_d = 2'd3; end
         default: begin sel_valid_d = 1'b0; sel_idx_d = 2'd0; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_valid_q <= 1'b0;
         sel_idx_q   <= 2'd0;
      end else begin
         sel_valid_q <= sel_valid_d;
         sel_idx_q   <= sel_idx_d;
      end
   end

   assign btn_level_o     = w_level[3:0];
   assign dip_level_o     = w_level[8:4];
   assign dip_sel_valid_o = sel_valid_q;
   assign dip_sel_idx_o   = sel_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_dip_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_btn_dip_conditioner : directed + random stimulus, sliding-window model,
//                          queue scoreboard compared by an independent monitor.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_btn_dip_conditioner;

   localparam int D  = 4;
   localparam int S  = 2;
   localparam int HL = S + D;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn   = '0;
   logic [4:0] dip   = '0;
   logic [3:0] btn_level_o;
   logic [3:0] btn_press_o;
   logic [4:0] dip_level_o;
   logic       dip_sel_valid_o;
   logic [1:0] dip_sel_idx_o;
   logic       relock_pulse_o;

   btn_dip_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3),
      .SYNC_STAGES    (S)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .btn_i          (btn),
      .dip_i          (dip),
      .btn_level_o    (btn_level_o),
      .btn_press_o    (btn_press_o),
      .dip_level_o    (dip_level_o),
      .dip_sel_valid_o(dip_sel_valid_o),
      .dip_sel_idx_o  (dip_sel_idx_o),
      .relock_pulse_o (relock_pulse_o)
   );

   always #5 clk = ~clk;

   // Output vector: {btn_level, btn_press, dip_level, sel_valid, sel_idx, relock}
   typedef struct {
      int          cyc;
      logic [16:0] v;
   } ev_t;

   ev_t exp_q[$];
   int  cyc      = 0;
   int  n_checks = 0;
   int  n_fail   = 0;

   function automatic logic is_evt(input logic [16:0] v, input logic [16:0] p);
      return (v != p) || (v[12:9] != 4'd0) || v[0];
   endfunction

   // Reference model: a level flips once the raw samples taken S..S+D-1 edges
   // ago all disagree with it; selection is one-hot decode of last cycle's level.
   initial begin
      logic [8:0]  hist [HL];
      logic [8:0]  lvl, nlvl;
      logic [3:0]  press, dsel;
      logic        rel, sv, all_opp;
      logic [1:0]  si;
      logic [16:0] ev, prev_ev;
      ev_t         e;
      lvl     = '0;
      prev_ev = '1;
      for (int k = 0; k < HL; k++) hist[k] = '0;
      forever begin
         @(posedge clk);
         cyc++;
         press = '0; rel = 1'b0; sv = 1'b0; si = 2'd0;
         if (!rst_n) begin
            for (int k = 0; k < HL; k++) hist[k] = '0;
            lvl = '0;
         end else begin
            for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {dip, btn};
            dsel = lvl[7:4];
            if ($countones(dsel) == 1) begin
               sv = 1'b1;
               for (int b = 0; b < 4; b++) if (dsel[b]) si = 2'(b);
            end
            nlvl = lvl;
            for (int c = 0; c < 9; c++) begin
               all_opp = 1'b1;
               for (int k = S; k < HL; k++) if (hist[k][c] == lvl[c]) all_opp = 1'b0;
               if (all_opp) nlvl[c] = ~lvl[c];
            end
            press = nlvl[3:0] & ~lvl[3:0];
            rel   = nlvl[8] & ~lvl[8];
            lvl   = nlvl;
         end
         ev = {lvl[3:0], press, lvl[8:4], sv, si, rel};
         if (is_evt(ev, prev_ev)) begin
            e.cyc = cyc;
            e.v   = ev;
            exp_q.push_back(e);
         end
         prev_ev = ev;
      end
   end

   initial begin
      logic [16:0] act, prev;
      ev_t         e;
      prev = '1;
      forever begin
         @(posedge clk);
         #2;
         act = {btn_level_o, btn_press_o, dip_level_o, dip_sel_valid_o,
                dip_sel_idx_o, relock_pulse_o};
         if (is_evt(act, prev)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output cyc=%0d actual=%05h required=no_event", cyc, act);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.v != act) begin
                  n_fail++;
                  $display("FAIL output_event cyc=%0d actual=%05h required=%05h at cyc=%0d",
                           cyc, act, e.v, e.cyc);
               end
            end
         end
         prev = act;
      end
   end

   task automatic drive(input logic [3:0] b, input logic [4:0] d, input logic r, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         btn   = b;
         dip   = d;
         rst_n = r;
      end
   endtask

   initial begin
      logic [3:0] rb;
      logic [4:0] rd;
      logic       rr;
      drive(4'b0000, 5'b00000, 1'b0, 3);
      drive(4'b0000, 5'b00000, 1'b1, 10);
      // clean press and release
      drive(4'b0001, 5'b00000, 1'b1, 20);
      drive(4'b0000, 5'b00000, 1'b1, 10);
      // bounce on btn[2] before settling high
      for (int k = 0; k < 2; k++) begin
         drive(4'b0100, 5'b00000, 1'b1, 2);
         drive(4'b0000, 5'b00000, 1'b1, 2);
      end
      drive(4'b0100, 5'b00000, 1'b1, 14);
      drive(4'b0000, 5'b00000, 1'b1, 10);
      // simultaneous presses
      drive(4'b1010, 5'b00000, 1'b1, 12);
      drive(4'b0000, 5'b00000, 1'b1, 10);
      // digit select and relock
      drive(4'b0000, 5'b00100, 1'b1, 10);
      drive(4'b0000, 5'b00110, 1'b1, 10);
      drive(4'b0000, 5'b10000, 1'b1, 10);
      drive(4'b0000, 5'b00000, 1'b1, 10);
      // reset while btn[1] is mid-debounce, button held through release
      drive(4'b0010, 5'b00000, 1'b1, 4);
      drive(4'b0010, 5'b00000, 1'b0, 3);
      drive(4'b0010, 5'b00000, 1'b1, 12);
      drive(4'b0000, 5'b00000, 1'b1, 10);
      // glitch one cycle too short
      drive(4'b1000, 5'b00000, 1'b1, 3);
      drive(4'b0000, 5'b00000, 1'b1, 10);
      // random segments with occasional resets
      for (int s = 0; s < 400; s++) begin
         rb = 4'($urandom);
         rd = 5'($urandom_range(0, 31));
         rr = ($urandom_range(0, 49) != 0);
         drive(rb, rd, rr, rr ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 3)));
      end
      drive(4'b0000, 5'b00000, 1'b1, 20);
      @(posedge clk);
      #4;
      while (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL missing_output actual=no_event required=%05h at cyc=%0d",
                  exp_q[0].v, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/btn_dip_conditioner.md
Name: btn_dip_conditioner

Overview:
- Input conditioning stage that sits directly upstream of the electronic-lock controller.
- Synchronises and debounces the 4 pushbuttons and 5 DIP sliders into the core clock domain.
- Emits clean levels, one-cycle press pulses, a digit-select valid flag and a relock pulse.
- The lock controller consumes these instead of raw pins, so it needs no per-button flag bookkeeping.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a new level (10 ms at 100 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- SYNC_STAGES, 2, synchroniser flops per input; legal values 2..3.

Ports:
- clk, input, 1, core clock, 100 MHz.
- rst_n, input, 1, asynchronous active-low reset.
- btn, input, 4, raw pushbuttons, active high, asynchronous.
- dip, input, 5, raw sliders, asynchronous; [3:0] digit select, [4] relock.
- btn_level, output, 4, debounced button levels.
- btn_press, output, 4, one-cycle pulse per debounced rising edge of btn_level.
- dip_level, output, 5, debounced slider levels.
- dip_sel_valid, output, 1, high when exactly one bit of dip_level[3:0] is set.
- dip_sel_idx, output, 2, index of the set bit; 0 when dip_sel_valid is low.
- relock_pulse, output, 1, one-cycle pulse on debounced rising edge of dip_level[4].

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: every synchroniser flop, counter, level and pulse output is 0. dip_sel_valid = 0, dip_sel_idx = 0.
- Channels: 9 independent, identical channels (btn[3:0], dip[4:0]). Each has a SYNC_STAGES-deep synchroniser, then a debounce FSM with a CNT_W counter.
- Channel FSM states:
  - STABLE_LO: counter 0. Synchronised input = 1 → WAIT_HI with counter = 1.
  - WAIT_HI: synchronised input = 0 → STABLE_LO with counter cleared (bounce rejected). Otherwise counter increments. When counter == DEBOUNCE_CYCLES-1 and input still 1 → STABLE_HI, level = 1, counter cleared.
  - STABLE_HI / WAIT_LO: mirror of the above for the falling direction.
- Latency: level changes exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles after a clean raw edge. Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- btn_press[i]: high for exactly the one cycle in which btn_level[i] goes 0→1. No pulse on release. Holding a button generates no repeats.
- Simultaneous events: presses on several buttons in the same cycle give the corresponding bits together in one btn_press vector; none are dropped or serialised.
- dip_sel_valid / dip_sel_idx: registered, updated one cycle after dip_level changes. Patterns 0000 or with ≥2 bits set → valid 0, idx 0. A press that occurs while dip_sel_valid = 0 still appears on btn_press; gating is the consumer's decision.
- relock_pulse: one cycle on dip_level[4] 0→1 only.
- Counter arithmetic: counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around.
- Reset mid-bounce: all state cleared immediately; no pulse is emitted during or on release of reset.
- Button held through reset release: treated as a fresh 0→1 edge, so btn_press fires SYNC_STAGES + DEBOUNCE_CYCLES cycles after rst_n deasserts. Same for relock_pulse.
- No combinational path from any input to any output; all outputs are registered.

Test Plan (all with DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean press: btn[0] 0→1 at cycle 10 and held → btn_level[0] = 1 from cycle 16; btn_press = 4'b0001 in cycle 16 only; no further pulses while held; release at 30 → level 0 at 36, no pulse.
- Bounce rejection: btn[2] toggles 1,0,1,0 each 2 cycles, then stays 1 from cycle 50 → exactly one btn_press[2] pulse, at cycle 56.
- Simultaneous: btn = 4'b1010 at cycle 5 → btn_press = 4'b1010 in a single cycle (11); other bits 0.
- Digit select: dip = 5'b00100 → dip_sel_valid = 1, idx = 2, one cycle after dip_level settles; dip = 5'b00110 → valid 0, idx 0; dip = 5'b10000 → relock_pulse once, valid 0.
- Reset mid-operation: btn[1] held, rst_n low for 3 cycles during WAIT_HI → all outputs 0 during reset; btn_press[1] 6 cycles after rst_n rises.
- Glitch: a 3-cycle (synchronised) high pulse on btn[3] → no btn_level or btn_press change at any time.
